// File: rtl/alu_pipe_stage.sv
// Two-stage pipelined ALU execution stage with valid/ready handshakes.
// S1 holds the operands and opcode; S2 holds the result and flags.
module And_for_N_bits #(
    parameter int Width = 4
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic [Width-1:0] y
);
    assign y = a & b;
endmodule

module alu_pipe_stage #(
    parameter int Width = 4
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [1:0]       Op,
    input  logic [Width-1:0] First,
    input  logic [Width-1:0] Second,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [Width-1:0] Result,
    output logic             Zero,
    output logic             Carry
);
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_e;

    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [Width-1:0] s1_a_q, s1_a_d;
    logic [Width-1:0] s1_b_q, s1_b_d;

    logic             s2_valid_q, s2_valid_d;
    logic [Width-1:0] s2_result_q, s2_result_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_carry_q, s2_carry_d;

    logic             s1_adv;
    logic             accept;
    logic [Width-1:0] and_y;
    logic [Width:0]   sum;
    logic [Width-1:0] ex_result;
    logic             ex_carry;

    And_for_N_bits #(.Width(Width)) u_and (
        .a(s1_a_q),
        .b(s1_b_q),
        .y(and_y)
    );

    assign sum = {1'b0, s1_a_q} + {1'b0, s1_b_q};

    always_comb begin
        ex_result = and_y;
        ex_carry  = 1'b0;
        unique case (op_e'(s1_op_q))
            OP_AND: ex_result = and_y;
            OP_OR:  ex_result = s1_a_q | s1_b_q;
            OP_XOR: ex_result = s1_a_q ^ s1_b_q;
            OP_ADD: begin
                ex_result = sum[Width-1:0];
                ex_carry  = sum[Width];
            end
            default: ex_result = and_y;
        endcase
    end

    // In_Ready depends combinationally on Out_Ready so a full pipe can refill
    // in the same cycle it drains.
    always_comb begin
        s1_adv   = s1_valid_q & (~s2_valid_q | Out_Ready);
        In_Ready = ~s1_valid_q | s1_adv;
        accept   = In_Valid & In_Ready;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = Op;
            s1_a_d     = First;
            s1_b_d     = Second;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_zero_d   = s2_zero_q;
        s2_carry_d  = s2_carry_q;
        if (s1_adv) begin
            s2_valid_d  = 1'b1;
            s2_result_d = ex_result;
            s2_zero_d   = (ex_result == '0);
            s2_carry_d  = ex_carry;
        end else if (Out_Ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_zero_q   <= 1'b0;
            s2_carry_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_zero_q   <= s2_zero_d;
            s2_carry_q  <= s2_carry_d;
        end
    end

    assign Out_Valid = s2_valid_q;
    assign Result    = s2_result_q;
    assign Zero      = s2_zero_q;
    assign Carry     = s2_carry_q;
endmodule

// File: tb/tb_alu_pipe_stage.sv
// Directed bench for alu_pipe_stage: single-op vector table plus
// streaming, backpressure and mid-flight reset sequences.
module tb_alu_pipe_stage;
    logic       Clock;
    logic       Reset_n;
    logic       In_Valid;
    logic       In_Ready;
    logic [1:0] Op;
    logic [3:0] First;
    logic [3:0] Second;
    logic       Out_Valid;
    logic       Out_Ready;
    logic [3:0] Result;
    logic       Zero;
    logic       Carry;

    int errors = 0;
    int checks = 0;

    alu_pipe_stage #(.Width(4)) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .In_Valid(In_Valid),
        .In_Ready(In_Ready),
        .Op(Op),
        .First(First),
        .Second(Second),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready),
        .Result(Result),
        .Zero(Zero),
        .Carry(Carry)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       z;
        logic       c;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [3:0] a, input logic [3:0] b);
        In_Valid = v;
        Op       = op;
        First    = a;
        Second   = b;
    endtask

    logic [3:0] s_exp[4];

    initial begin
        vecs[0] = '{2'b00, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0};
        vecs[1] = '{2'b11, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1};
        vecs[2] = '{2'b10, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0};
        vecs[3] = '{2'b01, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[4] = '{2'b11, 4'h7, 4'h8, 4'hF, 1'b0, 1'b0};
        vecs[5] = '{2'b11, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1};
        vecs[6] = '{2'b01, 4'hA, 4'h5, 4'hF, 1'b0, 1'b0};
        vecs[7] = '{2'b00, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[8] = '{2'b10, 4'hF, 4'hA, 4'h5, 1'b0, 1'b0};
        s_exp[0] = 4'h1;
        s_exp[1] = 4'h7;
        s_exp[2] = 4'h6;
        s_exp[3] = 4'h8;

        drive(1'b0, 2'b00, 4'h0, 4'h0);
        Out_Ready = 1'b0;
        Reset_n   = 1'b0;
        #3;
        chk("rst_out_valid", {31'b0, Out_Valid}, 32'd0);
        chk("rst_result", {28'b0, Result}, 32'd0);
        chk("rst_zero", {31'b0, Zero}, 32'd0);
        chk("rst_carry", {31'b0, Carry}, 32'd0);
        chk("rst_in_ready", {31'b0, In_Ready}, 32'd1);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Single-op vectors: accept, then result one edge later
        for (int i = 0; i < 9; i++) begin
            @(negedge Clock);
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            Out_Ready = 1'b1;
            @(posedge Clock);
            @(negedge Clock);
            drive(1'b0, 2'b00, 4'h0, 4'h0);
            @(posedge Clock);
            @(negedge Clock);
            chk($sformatf("vec%0d_valid", i), {31'b0, Out_Valid}, 32'd1);
            chk($sformatf("vec%0d_result", i), {28'b0, Result},
                {28'b0, vecs[i].res});
            chk($sformatf("vec%0d_zero", i), {31'b0, Zero}, {31'b0, vecs[i].z});
            chk($sformatf("vec%0d_carry", i), {31'b0, Carry},
                {31'b0, vecs[i].c});
            @(posedge Clock);
        end
        @(negedge Clock);
        chk("drained", {31'b0, Out_Valid}, 32'd0);

        // Streaming: 4 back-to-back ops on 3 and 5
        Out_Ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc > 0) @(negedge Clock);
            if (cyc < 4) begin
                drive(1'b1, cyc[1:0], 4'h3, 4'h5);
                #1;
                chk($sformatf("stream_in_ready%0d", cyc), {31'b0, In_Ready},
                    32'd1);
            end else begin
                drive(1'b0, 2'b00, 4'h0, 4'h0);
            end
            if (cyc >= 2) begin
                chk($sformatf("stream_valid%0d", cyc - 2), {31'b0, Out_Valid},
                    32'd1);
                chk($sformatf("stream_result%0d", cyc - 2), {28'b0, Result},
                    {28'b0, s_exp[cyc-2]});
            end
            @(posedge Clock);
        end
        @(negedge Clock);
        chk("stream_drained", {31'b0, Out_Valid}, 32'd0);

        // Backpressure: ADD 1+2, OR 4|8, XOR 6^3 with Out_Ready low
        Out_Ready = 1'b0;
        drive(1'b1, 2'b11, 4'h1, 4'h2);
        #1;
        chk("bp_ready_a", {31'b0, In_Ready}, 32'd1);
        @(posedge Clock);
        @(negedge Clock);
        drive(1'b1, 2'b01, 4'h4, 4'h8);
        #1;
        chk("bp_ready_b", {31'b0, In_Ready}, 32'd1);
        @(posedge Clock);
        @(negedge Clock);
        drive(1'b1, 2'b10, 4'h6, 4'h3);
        #1;
        chk("bp_ready_c", {31'b0, In_Ready}, 32'd0);
        chk("bp_valid", {31'b0, Out_Valid}, 32'd1);
        chk("bp_result_a", {28'b0, Result}, 32'h3);
        @(posedge Clock);
        @(negedge Clock);
        chk("bp_hold_ready", {31'b0, In_Ready}, 32'd0);
        chk("bp_hold_result", {28'b0, Result}, 32'h3);
        Out_Ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, In_Ready}, 32'd1);
        @(posedge Clock);
        @(negedge Clock);
        drive(1'b0, 2'b00, 4'h0, 4'h0);
        chk("bp_valid_b", {31'b0, Out_Valid}, 32'd1);
        chk("bp_result_b", {28'b0, Result}, 32'hC);
        @(posedge Clock);
        @(negedge Clock);
        chk("bp_valid_c", {31'b0, Out_Valid}, 32'd1);
        chk("bp_result_c", {28'b0, Result}, 32'h5);
        @(posedge Clock);
        @(negedge Clock);
        chk("bp_no_dup", {31'b0, Out_Valid}, 32'd0);

        // Mid-flight reset with both stages full
        Out_Ready = 1'b0;
        drive(1'b1, 2'b11, 4'h9, 4'h9);
        @(posedge Clock);
        @(negedge Clock);
        drive(1'b1, 2'b00, 4'hF, 4'hF);
        @(posedge Clock);
        @(negedge Clock);
        drive(1'b0, 2'b00, 4'h0, 4'h0);
        chk("mf_full_valid", {31'b0, Out_Valid}, 32'd1);
        chk("mf_full_result", {28'b0, Result}, 32'h2);
        chk("mf_full_carry", {31'b0, Carry}, 32'd1);
        chk("mf_full_ready", {31'b0, In_Ready}, 32'd0);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("mf_rst_valid", {31'b0, Out_Valid}, 32'd0);
        chk("mf_rst_result", {28'b0, Result}, 32'd0);
        chk("mf_rst_carry", {31'b0, Carry}, 32'd0);
        chk("mf_rst_ready", {31'b0, In_Ready}, 32'd1);
        @(negedge Clock);
        Reset_n   = 1'b1;
        Out_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk($sformatf("mf_post_idle%0d", i), {31'b0, Out_Valid}, 32'd0);
        end
        drive(1'b1, 2'b01, 4'h2, 4'h1);
        @(posedge Clock);
        @(negedge Clock);
        drive(1'b0, 2'b00, 4'h0, 4'h0);
        @(posedge Clock);
        @(negedge Clock);
        chk("mf_new_valid", {31'b0, Out_Valid}, 32'd1);
        chk("mf_new_result", {28'b0, Result}, 32'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
